// File: rtl/mic_pkg.sv
// mic_pkg: shared sample width, rate constants and peak-hold defaults for the mic chain.
package mic_pkg;
    localparam int MIC_W            = 12;
    localparam int CLK_HZ           = 100_000_000;
    localparam int SAMPLE_HZ        = 20_000;
    localparam int REFRESH_HZ       = 20;
    localparam int SAMPLE_DIV       = CLK_HZ / SAMPLE_HZ;
    localparam int WINDOW_DEF       = SAMPLE_HZ / REFRESH_HZ;
    localparam int DECAY_STEP_DEF   = 64;
    localparam int LOUD_ON_DEF      = 3600;
    localparam int LOUD_OFF_DEF     = 3300;
    localparam int LOUD_WINDOWS_DEF = 2;

    typedef logic [MIC_W-1:0] sample_t;

    // Held peak falls by at most step per window, floored at zero, never below the new max.
    function automatic sample_t decay_peak(sample_t peak, sample_t m, sample_t step);
        logic [MIC_W:0] d;
        d = {1'b0, peak} - {1'b0, step};
        d = d[MIC_W] ? '0 : d;
        return (m >= d[MIC_W-1:0]) ? m : d[MIC_W-1:0];
    endfunction
endpackage

// File: rtl/mic_window_max.sv
// mic_window_max: counts strobed samples and tracks the running max, flagging the closing sample.
module mic_window_max
    import mic_pkg::*;
#(
    parameter int WINDOW = WINDOW_DEF
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_sample_en,
    input  sample_t i_mic,
    output sample_t o_m,
    output logic    o_close
);
    localparam int CW = $clog2(WINDOW);

    logic [CW-1:0] r_cnt;
    sample_t       r_run;

    assign o_m     = (i_mic > r_run) ? i_mic : r_run;
    assign o_close = i_sample_en && (r_cnt == CW'(WINDOW - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_run <= '0;
        end else if (i_sample_en) begin
            r_cnt <= o_close ? '0 : r_cnt + 1'b1;
            r_run <= o_close ? '0 : o_m;
        end
    end
endmodule

// File: rtl/mic_peak_detector.sv
// mic_peak_detector: per-window decaying peak-hold level and debounced hysteretic loud flag.
module mic_peak_detector
    import mic_pkg::*;
#(
    parameter int WINDOW       = WINDOW_DEF,
    parameter int DECAY_STEP   = DECAY_STEP_DEF,
    parameter int LOUD_ON      = LOUD_ON_DEF,
    parameter int LOUD_OFF     = LOUD_OFF_DEF,
    parameter int LOUD_WINDOWS = LOUD_WINDOWS_DEF
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_sample_en,
    input  sample_t i_mic,
    output sample_t o_peak,
    output logic    o_peak_valid,
    output logic    o_loud,
    output sample_t o_win_max
);
    localparam int SW = $clog2(LOUD_WINDOWS + 1);

    sample_t       w_m;
    logic          w_close;
    logic          w_qual;
    logic [SW-1:0] w_streak_nxt;
    logic [SW-1:0] r_streak;

    mic_window_max #(.WINDOW(WINDOW)) u_win (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_sample_en (i_sample_en),
        .i_mic       (i_mic),
        .o_m         (w_m),
        .o_close     (w_close)
    );

    // A window qualifies when it argues for flipping the current loud state.
    assign w_qual       = o_loud ? (w_m < sample_t'(LOUD_OFF)) : (w_m >= sample_t'(LOUD_ON));
    assign w_streak_nxt = w_qual ? r_streak + 1'b1 : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_peak       <= '0;
            o_peak_valid <= 1'b0;
            o_loud       <= 1'b0;
            o_win_max    <= '0;
            r_streak     <= '0;
        end else begin
            o_peak_valid <= w_close;
            if (w_close) begin
                o_win_max <= w_m;
                o_peak    <= decay_peak(o_peak, w_m, sample_t'(DECAY_STEP));
                if (w_streak_nxt == SW'(LOUD_WINDOWS)) begin
                    o_loud   <= ~o_loud;
                    r_streak <= '0;
                end else begin
                    r_streak <= w_streak_nxt;
                end
            end
        end
    end
endmodule

// File: doc/mic_peak_detector.md
Name: mic_peak_detector

Overview:
- Upstream conditioning stage between the 12-bit microphone sample stream and the 20 Hz volume/LED indicator.
- Takes one raw sample per sample_en strobe (20 kHz) and tracks the maximum over a fixed window of samples.
- Once per window, publishes a decaying peak-hold level and a debounced "loud" flag; downstream samples these at its refresh rate.

Parameters:
- WINDOW, 1000, samples per measurement window (1000 @ 20 kHz = 50 ms, one 20 Hz refresh period); legal 2..65535
- DECAY_STEP, 64, amount the held peak may fall per window when the new window max is lower
- LOUD_ON, 3600, loud asserts when the window max is greater than or equal to this value
- LOUD_OFF, 3300, loud deasserts when the window max is strictly below this value; must be below LOUD_ON
- LOUD_WINDOWS, 2, consecutive qualifying windows required to change loud

Ports:
- CLK  in  1  system clock (100 MHz)
- RST  in  1  asynchronous, active-high reset
- sample_en  in  1  single-CLK strobe, one per mic sample (20 kHz)
- MIC_in  in  12  unsigned mic sample; valid when sample_en = 1
- peak  out  12  decaying peak-hold level, registered
- peak_valid  out  1  one-CLK pulse when peak/loud update
- loud  out  1  hysteretic over-threshold flag, registered
- win_max  out  12  raw maximum of the last completed window (debug/verification)

Behaviour:
- Reset (async, any time):
  - Outputs: peak = 0, peak_valid = 0, loud = 0, win_max = 0.
  - Internals: sample counter = 0, running max = 0, loud streak counter = 0.
  - A window in progress is discarded; the first window after release starts clean.
- Accumulation (only on CLK edges with sample_en = 1):
  - run_max <= max(run_max, MIC_in); cnt <= cnt + 1.
  - Cycles with sample_en = 0 change nothing.
  - cnt width is clog2(WINDOW).
- Window close: on the sample_en cycle where cnt == WINDOW-1.
  - m = max(run_max, MIC_in), so the closing sample is included.
  - win_max <= m.
  - Held-peak update, 13-bit arithmetic with saturation at 0:
    - if m >= peak: peak <= m
    - else: peak <= max(m, peak - DECAY_STEP), where peak - DECAY_STEP saturates at 0
  - Loud hysteresis:
    - if loud = 0 and m >= LOUD_ON: streak increments, else streak clears.
    - if loud = 1 and m < LOUD_OFF: streak increments, else streak clears.
    - When streak reaches LOUD_WINDOWS: loud toggles and streak clears, in the same close cycle.
    - m between LOUD_OFF and LOUD_ON clears streak and holds loud.
  - peak_valid = 1 for exactly this one cycle (registered; updated values are visible the same cycle peak_valid is high).
  - run_max <= 0 and cnt <= 0, so the next sample starts a new window.
- Latency: peak/loud/win_max/peak_valid appear one CLK after the closing sample_en edge.
- No back-pressure: the consumer must sample within one window. A missed pulse is not buffered; the values simply hold until the next close.
- Boundaries:
  - MIC_in = 4095 every sample: peak = 4095, no overflow.
  - MIC_in = 0 forever after a peak: peak decays by DECAY_STEP per window to exactly 0, never wraps.
  - sample_en held high continuously is legal; a window then spans WINDOW consecutive cycles.

Decomposition:
- Shared package mic_pkg:
  - MIC_W = 12
  - default thresholds and DECAY_STEP
  - the 20 kHz / 20 Hz rate constants already shared with the indicator and clock dividers
- One natural sub-module: mic_window_max (counter + running max + close strobe, outputs m and close).
- Parent mic_peak_detector holds the peak-hold decay and the loud hysteresis logic.

Test Plan:
- Reset mid-window: feed 500 samples of 3000, pulse RST, then 1000 samples of 1000 -> first peak_valid after 1000 samples; win_max = 1000, peak = 1000.
- Ramp in window: MIC_in = sample index 0..999 -> win_max = 999, peak = 999, peak_valid a single cycle.
- Closing sample is the maximum: 999 samples of 100, then the last sample = 3500 -> win_max = 3500.
- Decay: one window of 2000, then windows of 0 -> peak = 2000, 1936, 1872, ..., reaching exactly 0 after 32 zero-windows and staying 0.
- Hysteresis: windows with max 3700, 3700 -> loud rises at the 2nd close. Then windows 3400, 3400 -> loud stays 1. Then 3200, 3400, 3200, 3200 -> loud falls at the 4th close.
- Gapped strobe: sample_en every 5000 CLK with a random gap, MIC_in = 4095 -> exactly one peak_valid per 1000 strobes; peak = 4095, loud = 1 after the 2nd window.
